sample_prefetch: RTL and testbench

Downstream stage of the sine sample generator. It requests samples one at a time by pulsing `generate_next` and captures each result on `sample_ready_in`. Each captured sample is scaled by a 4-bit volume and queued in a small FIFO. The codec interface drains the FIFO one sample per `new_frame` request, and a sticky flag reports underflow.

---
 rtl/audio_pkg.sv | 27 ++
 rtl/sample_fifo.sv | 79 +++++++
 rtl/sample_prefetch.sv | 121 ++++++++++++
 tb/tb_sample_prefetch.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample path.
// The volume scaler is kept here so every block sees the same product width.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int VOL_W    = 4;
  localparam int PROD_W   = SAMPLE_W + VOL_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } prefetch_state_t;

  // Signed sample times unsigned gain; the extra zero bit keeps volume non-negative.
  function automatic logic signed [PROD_W-1:0] scale_product(
    input logic [SAMPLE_W-1:0] sample,
    input logic [VOL_W-1:0]    vol
  );
    logic signed [PROD_W-1:0] s_ext;
    logic signed [PROD_W-1:0] v_ext;
    s_ext = PROD_W'($signed(sample));
    v_ext = PROD_W'({1'b0, vol});
    return s_ext * v_ext;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with registered read data.
// A read of an empty FIFO, or a read during flush, returns zero instead of stale data.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !flush && (count_q != FULL_C);
  assign do_rd = rd_en && !flush && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (do_wr && !do_rd) begin
      count_d = count_q + CW'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_wr) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
      if (rd_en) begin
        rd_data_q <= do_rd ? mem_q[rd_ptr_q] : '0;
      end
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/sample_prefetch.sv
// Requests samples from the sine generator, scales them by volume and queues them
// for the codec, which drains one sample per new_frame.
//
//   state | meaning
//   IDLE  | no request outstanding; issue one when play=1 and FIFO not full
//   REQ   | generate_next high this cycle; timeout counter cleared
//   WAIT  | waiting for sample_ready_in; retry after TIMEOUT+1 cycles
module sample_prefetch
  import audio_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play,
  input  logic                   done,
  input  logic [VOL_W-1:0]       volume,
  input  logic                   sample_ready_in,
  input  logic [SAMPLE_W-1:0]    sample_in,
  output logic                   generate_next,
  input  logic                   new_frame,
  output logic [SAMPLE_W-1:0]    frame_sample,
  output logic                   frame_valid,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [3:0]       TIMEOUT_C = 4'(TIMEOUT);

  prefetch_state_t          state_q;
  logic                     gen_q;
  logic [3:0]               tmo_q;
  logic                     underflow_q;
  logic                     frame_valid_q;
  logic signed [PROD_W-1:0] product;
  logic [SAMPLE_W-1:0]      scaled;
  logic                     product_unused;
  logic                     wr_en;
  logic [CNT_W-1:0]         fifo_count;

  // Keeping bits [19:4] is an arithmetic shift right by 4, rounding toward -inf.
  assign product        = scale_product(sample_in, volume);
  assign scaled         = product[SAMPLE_W+VOL_W-1:VOL_W];
  assign product_unused = ^{product[PROD_W-1], product[VOL_W-1:0]};

  assign wr_en = (state_q == WAIT) && sample_ready_in && !done;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (new_frame),
    .flush   (done),
    .wr_data (scaled),
    .rd_data (frame_sample),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      gen_q         <= 1'b0;
      tmo_q         <= '0;
      underflow_q   <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= new_frame;
      // A pop coinciding with done is answered with zero but is not an underflow.
      if (new_frame && !done && (fifo_count == '0)) begin
        underflow_q <= 1'b1;
      end
      if (done) begin
        state_q <= IDLE;
        gen_q   <= 1'b0;
        tmo_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            gen_q <= 1'b0;
            if (play && (fifo_count < DEPTH_C)) begin
              state_q <= REQ;
              gen_q   <= 1'b1;
            end
          end
          REQ: begin
            state_q <= WAIT;
            gen_q   <= 1'b0;
            tmo_q   <= '0;
          end
          WAIT: begin
            if (sample_ready_in) begin
              state_q <= IDLE;
            end else if (tmo_q == TIMEOUT_C) begin
              state_q <= REQ;
              gen_q   <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 4'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            gen_q   <= 1'b0;
            tmo_q   <= '0;
          end
        endcase
      end
    end
  end

  assign generate_next = gen_q;
  assign frame_valid   = frame_valid_q;
  assign underflow     = underflow_q;
  assign level         = fifo_count;

endmodule

// File: tb/tb_sample_prefetch.sv
// Self-checking bench for sample_prefetch: scaling table, hand-written corner
// sequences, then a randomized run against a queue-based reference model.
module tb_sample_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic        done;
  logic [3:0]  volume;
  logic        sample_ready_in;
  logic [15:0] sample_in;
  logic        generate_next;
  logic        new_frame;
  logic [15:0] frame_sample;
  logic        frame_valid;
  logic        underflow;
  logic [3:0]  level;

  int nerr = 0;
  int nchk = 0;

  sample_prefetch #(.DEPTH(8), .TIMEOUT(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .play            (play),
    .done            (done),
    .volume          (volume),
    .sample_ready_in (sample_ready_in),
    .sample_in       (sample_in),
    .generate_next   (generate_next),
    .new_frame       (new_frame),
    .frame_sample    (frame_sample),
    .frame_valid     (frame_valid),
    .underflow       (underflow),
    .level           (level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] smp;
    logic [3:0]  vol;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [15:0] ref_scale(input logic [15:0] s, input logic [3:0] v);
    int p;
    int r;
    p = int'($signed(s)) * int'(v);
    r = p >>> 4;
    return r[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; play = 1'b0; done = 1'b0; new_frame = 1'b0;
    sample_ready_in = 1'b0; sample_in = '0; volume = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_gen(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (generate_next) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL wait_gen: no generate_next within %0d cycles", budget);
    end
  endtask

  // Called in the REQ cycle: answer in the first WAIT cycle.
  task automatic respond(input logic [15:0] s, input logic [3:0] v);
    tick();
    sample_ready_in = 1'b1; sample_in = s; volume = v;
    tick();
    sample_ready_in = 1'b0;
  endtask

  task automatic pop_check(input string nm, input logic [15:0] exp);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    chk({nm, "_valid"}, frame_valid, 1);
    chk(nm, frame_sample, exp);
  endtask

  initial begin
    int gens;
    int cd;
    int gq [$];
    logic [15:0] mq [$];
    bit outstanding;
    bit pend;
    bit uf_m;
    logic [15:0] exp_fs;
    int pop_pct;

    vecs[0] = '{16'h4000, 4'd8,  16'h2000};
    vecs[1] = '{16'hC000, 4'd8,  16'hE000};
    vecs[2] = '{16'h7FFF, 4'd15, 16'h77FF};
    vecs[3] = '{16'h8000, 4'd15, 16'h8800};
    vecs[4] = '{16'h1234, 4'd0,  16'h0000};
    vecs[5] = '{16'hFFFF, 4'd1,  16'hFFFF};
    vecs[6] = '{16'hFFF1, 4'd1,  16'hFFFF};
    vecs[7] = '{16'h0010, 4'd1,  16'h0001};
    vecs[8] = '{16'h000F, 4'd15, 16'h000E};
    vecs[9] = '{16'hFFF0, 4'd3,  16'hFFFD};

    // Reset values
    do_reset();
    chk("rst_gen", generate_next, 0);
    chk("rst_fs", frame_sample, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_level", level, 0);

    // Scaling table
    for (int i = 0; i < 10; i++) begin
      play = 1'b1;
      wait_gen(10);
      play = 1'b0;
      respond(vecs[i].smp, vecs[i].vol);
      chk("tbl_level1", level, 1);
      pop_check("tbl_sample", vecs[i].exp);
      chk("tbl_level0", level, 0);
    end
    chk("tbl_no_uf", underflow, 0);

    // Full stop: eight requests fill the FIFO, one pop allows one more
    do_reset();
    play = 1'b1;
    gens = 0; cd = 0;
    for (int c = 0; c < 150; c++) begin
      sample_ready_in = 1'b0;
      if (generate_next) begin
        gens++; cd = 2;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          sample_ready_in = 1'b1; sample_in = 16'(gens * 16); volume = 4'd15;
        end
      end
      tick();
    end
    sample_ready_in = 1'b0;
    chk("full_gens", gens, 8);
    chk("full_level", level, 8);
    pop_check("full_pop", ref_scale(16'd16, 4'd15));
    gens = 0; cd = 0;
    for (int c = 0; c < 60; c++) begin
      sample_ready_in = 1'b0;
      if (generate_next) begin
        gens++; cd = 2;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          sample_ready_in = 1'b1; sample_in = 16'h0100; volume = 4'd15;
        end
      end
      tick();
    end
    sample_ready_in = 1'b0;
    chk("full_refill_gens", gens, 1);
    chk("full_refill_level", level, 8);

    // Timeout retry
    do_reset();
    play = 1'b1;
    gq.delete();
    for (int c = 0; c < 60; c++) begin
      if (generate_next) gq.push_back(c);
      tick();
    end
    chk("tmo_count", gq.size(), 4);
    if (gq.size() > 0) chk("tmo_first", gq[0], 1);
    for (int i = 1; i < gq.size(); i++) chk("tmo_period", gq[i] - gq[i-1], 17);
    chk("tmo_level", level, 0);

    // Underflow, sticky
    do_reset();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    chk("uf_fv", frame_valid, 1);
    chk("uf_fs", frame_sample, 0);
    chk("uf_flag", underflow, 1);
    for (int c = 0; c < 5; c++) tick();
    chk("uf_sticky", underflow, 1);

    // Write and pop in the same cycle on an empty FIFO
    do_reset();
    play = 1'b1;
    wait_gen(10);
    play = 1'b0;
    tick();
    sample_ready_in = 1'b1; sample_in = 16'h4000; volume = 4'd8; new_frame = 1'b1;
    tick();
    sample_ready_in = 1'b0; new_frame = 1'b0;
    chk("wp_fv", frame_valid, 1);
    chk("wp_fs", frame_sample, 0);
    chk("wp_uf", underflow, 1);
    chk("wp_level", level, 1);
    pop_check("wp_pop", 16'h2000);
    chk("wp_level0", level, 0);

    // Done flush during WAIT with a coincident pop
    do_reset();
    play = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_gen(20);
      respond(16'(16'h1000 * (k + 1)), 4'd4);
    end
    chk("done_pre_level", level, 5);
    wait_gen(20);
    play = 1'b0;
    tick();
    done = 1'b1; new_frame = 1'b1;
    tick();
    done = 1'b0; new_frame = 1'b0;
    chk("done_level", level, 0);
    chk("done_fv", frame_valid, 1);
    chk("done_fs", frame_sample, 0);
    chk("done_uf", underflow, 0);
    tick();
    sample_ready_in = 1'b1; sample_in = 16'h7000; volume = 4'd15;
    tick();
    sample_ready_in = 1'b0;
    chk("done_stray_level", level, 0);
    chk("done_stray_gen", generate_next, 0);
    play = 1'b1;
    tick();
    chk("done_idle_req", generate_next, 1);
    play = 1'b0;

    // Reset mid-WAIT
    do_reset();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    play = 1'b1;
    wait_gen(10);
    play = 1'b0;
    respond(16'h4000, 4'd8);
    pop_check("rw_pop", 16'h2000);
    play = 1'b1;
    wait_gen(10);
    respond(16'h1111, 4'd8);
    wait_gen(10);
    play = 1'b0;
    tick();
    reset = 1'b0; new_frame = 1'b1;
    tick();
    reset = 1'b1; new_frame = 1'b0;
    chk("rw_gen", generate_next, 0);
    chk("rw_fs", frame_sample, 0);
    chk("rw_fv", frame_valid, 0);
    chk("rw_uf", underflow, 0);
    chk("rw_level", level, 0);
    tick();
    sample_ready_in = 1'b1; sample_in = 16'h4000; volume = 4'd8;
    tick();
    sample_ready_in = 1'b0;
    chk("rw_stray_level", level, 0);
    play = 1'b1;
    wait_gen(10);
    play = 1'b0;
    respond(16'h7FFF, 4'd0);
    pop_check("rw_vol0", 16'h0000);

    // Randomized run against a queue model
    do_reset();
    mq.delete();
    outstanding = 1'b0; pend = 1'b0; uf_m = 1'b0; exp_fs = '0; cd = 0;
    for (int it = 0; it < 3000; it++) begin
      chk("rnd_level", level, mq.size());
      chk("rnd_fv", frame_valid, pend);
      if (pend) chk("rnd_fs", frame_sample, exp_fs);
      chk("rnd_uf", underflow, uf_m);
      if (generate_next) begin
        chk("rnd_one_outstanding", outstanding, 0);
        chk("rnd_gen_not_full", level < 4'd8, 1);
      end

      sample_ready_in = 1'b0;
      if (outstanding) begin
        cd--;
        if (cd == 0) begin
          sample_ready_in = 1'b1;
          sample_in = 16'($urandom);
          volume = 4'($urandom);
          outstanding = 1'b0;
        end
      end
      if (generate_next) begin
        outstanding = 1'b1;
        cd = $urandom_range(1, 6);
      end
      pop_pct = (it < 1500) ? 10 : 40;
      new_frame = ($urandom_range(0, 99) < pop_pct);
      play = ($urandom_range(0, 99) < 85);

      pend = new_frame;
      if (new_frame) begin
        if (mq.size() == 0) begin
          exp_fs = '0;
          uf_m = 1'b1;
        end else begin
          exp_fs = mq.pop_front();
        end
      end
      if (sample_ready_in) mq.push_back(ref_scale(sample_in, volume));
      tick();
    end
    new_frame = 1'b0; play = 1'b0; sample_ready_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
